// File: rtl/conv_window3_pkg.sv
// Shared types for the 3x3 convolution window path.
// Pixel, column and window types plus default image size.
package packConv;
  localparam int NBITS = 16;
  localparam int IMG_W_DEF = 32;
  localparam int IMG_H_DEF = 32;

  typedef logic [NBITS-1:0] regC;
  typedef logic [0:8][NBITS-1:0] param9;
  typedef logic [0:2][NBITS-1:0] win_col3;
endpackage

// File: rtl/conv_window3_if.sv
// Pixel-in / window-out handshake bundle.
// slave: window generator; master: source/sink side.
interface conv_window3_if;
  import packConv::*;

  regC   in_pixel;
  logic  in_valid;
  logic  in_ready;
  param9 out_win;
  logic  out_valid;
  logic  out_ready;
  logic  frame_done;

  modport slave (
    input  in_pixel, in_valid, out_ready,
    output in_ready, out_win, out_valid,
    output frame_done
  );

  modport master (
    output in_pixel, in_valid, out_ready,
    input  in_ready, out_win, out_valid,
    input  frame_done
  );
endinterface

// File: rtl/conv_window3_line_buffer.sv
// Circular line buffer: dout is the value shifted in DEPTH shifts ago.
// Ports: clock, reset (async low), shift_en, din, dout.
module line_buffer
  import packConv::*;
#(
  parameter int DEPTH = IMG_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic shift_en,
  input  regC  din,
  output regC  dout
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  regC mem [DEPTH];
  logic [AW-1:0] addr;

  // Read-before-write: the slot about to be overwritten is the oldest.
  assign dout = mem[addr];

  always_ff @(posedge clock) begin
    if (shift_en) mem[addr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr <= '0;
    end else if (shift_en) begin
      addr <= (addr == LAST) ? '0 : addr + 1'b1;
    end
  end
endmodule

// File: rtl/conv_window3.sv
// Streaming 3x3 window generator over a raster pixel stream.
// Ports: clock, reset (async low), clear (sync restart), bus (slave).
module conv_window3
  import packConv::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  conv_window3_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  param9   win;
  param9   winNext;
  win_col3 newCol;
  regC     lb0Out;
  regC     lb1Out;
  logic    outValid;
  logic    frameDone;
  logic    accept;
  logic    shiftEn;
  logic    emit;
  logic    lastPix;

  assign bus.in_ready   = !outValid || bus.out_ready;
  assign bus.out_valid  = outValid;
  assign bus.frame_done = frameDone;
  assign bus.out_win    = win;

  assign accept  = bus.in_valid && bus.in_ready;
  assign shiftEn = accept && !clear;
  assign emit    = (row >= ROW_TWO) && (col >= COL_TWO);
  assign lastPix = (row == ROW_LAST) && (col == COL_LAST);
  assign newCol  = {lb1Out, lb0Out, bus.in_pixel};

  line_buffer #(.DEPTH(IMG_W)) u_lb0 (
    .clock    (clock),
    .reset    (reset),
    .shift_en (shiftEn),
    .din      (bus.in_pixel),
    .dout     (lb0Out)
  );

  line_buffer #(.DEPTH(IMG_W)) u_lb1 (
    .clock    (clock),
    .reset    (reset),
    .shift_en (shiftEn),
    .din      (lb0Out),
    .dout     (lb1Out)
  );

  always_comb begin
    winNext = win;
    for (int r = 0; r < 3; r++) begin
      winNext[r*3]   = win[r*3+1];
      winNext[r*3+1] = win[r*3+2];
      winNext[r*3+2] = newCol[r];
    end
  end

  // The window register doubles as the output register: it only
  // moves on accept, and accept is blocked while a window stalls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col       <= '0;
      row       <= '0;
      win       <= '0;
      outValid  <= 1'b0;
      frameDone <= 1'b0;
    end else if (clear) begin
      col       <= '0;
      row       <= '0;
      outValid  <= 1'b0;
      frameDone <= 1'b0;
    end else if (accept) begin
      win       <= winNext;
      outValid  <= emit;
      frameDone <= lastPix;
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end else if (bus.out_ready) begin
      outValid  <= 1'b0;
      frameDone <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv_window3.sv
// Scoreboard bench for conv_window3 on an 8x6 frame.
// Driver pushes expected windows; monitor pops on each handshake.
module tb_conv_window3;
  import packConv::*;

  localparam int W = 8;
  localparam int H = 6;

  typedef struct {
    param9 w;
    logic  fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  conv_window3_if bus();

  conv_window3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clock (clk),
    .reset (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int popCount = 0;

  task automatic chk(input string nm,
                     input logic [143:0] act,
                     input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic regC pix(input int base, input int r,
                              input int c);
    return regC'(base + r*16 + c);
  endfunction

  // Window centred at (r-1,c-1): rows r-2..r, cols c-2..c.
  function automatic param9 winAt(input int base, input int r,
                                  input int c);
    param9 w;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[dr*3+dc] = pix(base, r-2+dr, c-2+dc);
    return w;
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the accept.
  task automatic sendPix(input int base, input int idx);
    int r;
    int c;
    int n;
    exp_t e;
    r = idx / W;
    c = idx % W;
    bus.in_pixel = pix(base, r, c);
    bus.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        errors++;
        $display("FAIL acceptTimeout: idx %0d never accepted", idx);
        break;
      end
    end
    if (r >= 2 && c >= 2) begin
      e.w = winAt(base, r, c);
      e.fd = (r == H-1) && (c == W-1);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic sendRange(input int base, input int from,
                           input int to);
    for (int i = from; i < to; i++) sendPix(base, i);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      popCount++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpectedWin: got %h expected none",
                 bus.out_win);
      end else begin
        e = q.pop_front();
        chk("win", bus.out_win, e.w);
        chk("frameDone", bus.frame_done, e.fd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam param9 FIRST_A = {16'd0, 16'd1, 16'd2,
                               16'd16, 16'd17, 16'd18,
                               16'd32, 16'd33, 16'd34};
  localparam param9 FIRST_B = {16'h100, 16'h101, 16'h102,
                               16'h110, 16'h111, 16'h112,
                               16'h120, 16'h121, 16'h122};
  localparam param9 LAST_A = {16'd53, 16'd54, 16'd55,
                              16'd69, 16'd70, 16'd71,
                              16'd85, 16'd86, 16'd87};

  initial begin
    bus.in_pixel = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;

    @(negedge clk);
    chk("rstValid", bus.out_valid, 1'b0);
    chk("rstDone", bus.frame_done, 1'b0);
    chk("rstWin", bus.out_win, '0);
    chk("rstReady", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame A with a 5-cycle stall, then frame B back to back.
    sendRange(0, 0, 19);
    @(negedge clk);
    chk("firstWinA", bus.out_win, FIRST_A);
    chk("firstValidA", bus.out_valid, 1'b1);
    @(posedge clk);
    #1;
    sendPix(0, 19);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pixel = pix(0, 2, 4);
    repeat (5) begin
      @(negedge clk);
      chk("stallReady", bus.in_ready, 1'b0);
      chk("stallValid", bus.out_valid, 1'b1);
      chk("stallWin", bus.out_win, winAt(0, 2, 3));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b0;
    sendRange(0, 20, 48);
    sendRange(256, 0, 19);
    @(negedge clk);
    chk("firstWinB", bus.out_win, FIRST_B);
    @(posedge clk);
    #1;
    sendRange(256, 19, 48);
    repeat (2) @(negedge clk);
    chk("winsAB", popCount, 48);

    // Reset in the middle of row 2, then a clean frame.
    @(posedge clk);
    #1;
    sendRange(0, 0, 21);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("midRstValid", bus.out_valid, 1'b0);
      chk("midRstWin", bus.out_win, '0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sendRange(0, 0, 19);
    @(negedge clk);
    chk("firstWinC", bus.out_win, FIRST_A);
    @(posedge clk);
    #1;
    sendRange(0, 19, 48);
    @(negedge clk);
    chk("lastWinC", bus.out_win, LAST_A);
    chk("lastDoneC", bus.frame_done, 1'b1);
    @(posedge clk);
    #1;

    // Clear collides with the pixel at (4,3).
    sendRange(0, 0, 35);
    bus.in_valid = 1'b1;
    bus.in_pixel = pix(0, 4, 3);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("clearValid", bus.out_valid, 1'b0);
    chk("clearDone", bus.frame_done, 1'b0);
    @(posedge clk);
    #1;
    sendRange(512, 0, 48);

    repeat (4) @(negedge clk);
    chk("queueEmpty", q.size(), 0);
    chk("winTotal", popCount, 112);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
